// File: rtl/mem_arbiter.sv
// Two-requester arbiter in front of a single-port synchronous data memory.
// Define MEM_ARB_ROUND_ROBIN_EN for round-robin contention; otherwise port 0 has fixed priority.
module mem_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_i,
    input  logic              we0_i,
    input  logic [ADDR_W-1:0] addr0_i,
    input  logic [DATA_W-1:0] wdata0_i,
    input  logic              req1_i,
    input  logic              we1_i,
    input  logic [ADDR_W-1:0] addr1_i,
    input  logic [DATA_W-1:0] wdata1_i,
    output logic              gnt0_o,
    output logic              rvalid0_o,
    output logic [DATA_W-1:0] rdata0_o,
    output logic              gnt1_o,
    output logic              rvalid1_o,
    output logic [DATA_W-1:0] rdata1_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic [1:0]        fsm_state
);

    // Handshake: a requester holds reqk_i and its attributes until gntk_o; the
    // request is sampled only in IDLE, gntk_o pulses in ACCESS, rvalidk_o in RESP.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

    state_t              state;
    state_t              state_nx;
    logic                take;
    logic                pick;
    logic                win;
    logic                we_r;
    logic [ADDR_W-1:0]   addr_r;
    logic [DATA_W-1:0]   wdata_r;
    logic [DATA_W-1:0]   rdata0_r;
    logic [DATA_W-1:0]   rdata1_r;

`ifdef MEM_ARB_ROUND_ROBIN_EN
    logic ptr;

    // Pointer names the preferred port and always moves away from the winner.
    always_comb pick = (req0_i && req1_i) ? ptr : req1_i;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= 1'b0;
        end else if (take) begin
            ptr <= ~pick;
        end
    end
`else
    always_comb pick = ~req0_i;
`endif

    always_comb begin
        state_nx = state;
        take     = 1'b0;
        case (state)
            IDLE: begin
                if (req0_i || req1_i) begin
                    take     = 1'b1;
                    state_nx = ACCESS;
                end
            end
            ACCESS:  state_nx = we_r ? IDLE : RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            win      <= 1'b0;
            we_r     <= 1'b0;
            addr_r   <= '0;
            wdata_r  <= '0;
            rdata0_r <= '0;
            rdata1_r <= '0;
        end else begin
            if (take) begin
                win     <= pick;
                we_r    <= pick ? we1_i : we0_i;
                addr_r  <= pick ? addr1_i : addr0_i;
                wdata_r <= pick ? wdata1_i : wdata0_i;
            end
            if (state == RESP) begin
                if (win) begin
                    rdata1_r <= mem_rdata_i;
                end else begin
                    rdata0_r <= mem_rdata_i;
                end
            end
        end
    end

    // Read data is forwarded during RESP so it lines up with rvalid, then held.
    always_comb begin
        gnt0_o      = (state == ACCESS) && !win;
        gnt1_o      = (state == ACCESS) && win;
        rvalid0_o   = (state == RESP) && !win;
        rvalid1_o   = (state == RESP) && win;
        mem_we_o    = (state == ACCESS) && we_r;
        mem_addr_o  = addr_r;
        mem_wdata_o = wdata_r;
        rdata0_o    = rvalid0_o ? mem_rdata_i : rdata0_r;
        rdata1_o    = rvalid1_o ? mem_rdata_i : rdata1_r;
        fsm_state   = state;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic
// against a transaction-level reference (sample times, spacing, priority, memory image).
module tb_mem_arbiter;
    localparam int AW = 14;
    localparam int DW = 32;
    localparam int NW = 1 << AW;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic req0, we0, req1, we1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic [1:0] fsm_state;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_i(req0), .we0_i(we0), .addr0_i(addr0), .wdata0_i(wdata0),
        .req1_i(req1), .we1_i(we1), .addr1_i(addr1), .wdata1_i(wdata1),
        .gnt0_o(gnt0), .rvalid0_o(rvalid0), .rdata0_o(rdata0),
        .gnt1_o(gnt1), .rvalid1_o(rvalid1), .rdata1_o(rdata1),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata), .fsm_state(fsm_state)
    );

    function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
        return {18'h2a5a5, a};
    endfunction

    // Memory the DUT talks to: data valid the cycle after the address.
    logic [DW-1:0] mem [0:NW-1];
    bit            mem_seen [0:NW-1] = '{default: 1'b0};
    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr]      <= mem_wdata;
            mem_seen[mem_addr] <= 1'b1;
        end
        mem_rdata <= mem_seen[mem_addr] ? mem[mem_addr] : init_val(mem_addr);
    end

    function automatic logic [DW-1:0] mem_rd(input logic [AW-1:0] a);
        return mem_seen[a] ? mem[a] : init_val(a);
    endfunction

    // Reference memory image, updated by the model only.
    logic [DW-1:0] ref_mem [0:NW-1];
    bit            ref_seen [0:NW-1] = '{default: 1'b0};

    function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
        return ref_seen[a] ? ref_mem[a] : init_val(a);
    endfunction

    int checks = 0;
    int errors = 0;

    int            w, free_at, acc_w, resp_w;
    bit            acc_port, acc_we, pref;
    logic [AW-1:0] acc_addr, exp_addr;
    logic [DW-1:0] acc_wdata, exp_wdata, pend_data, exp_rd0, exp_rd1;
    int            g0, g1;
    logic [DW-1:0] orig;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_window();
        if (w == resp_w) begin
            if (acc_port) exp_rd1 = pend_data;
            else          exp_rd0 = pend_data;
        end
        chk1("gnt0", gnt0, (w == acc_w) && !acc_port);
        chk1("gnt1", gnt1, (w == acc_w) && acc_port);
        chk1("rvalid0", rvalid0, (w == resp_w) && !acc_port);
        chk1("rvalid1", rvalid1, (w == resp_w) && acc_port);
        chk1("mem_we", mem_we, (w == acc_w) && acc_we);
        chk32("mem_addr", {{(DW-AW){1'b0}}, mem_addr}, {{(DW-AW){1'b0}}, exp_addr});
        chk32("mem_wdata", mem_wdata, exp_wdata);
        chk32("rdata0", rdata0, exp_rd0);
        chk32("rdata1", rdata1, exp_rd1);
    endtask

    // Called at a falling edge with inputs already set for the next rising edge.
    task automatic tick();
        int e;
        bit win;
        e = w + 1;
        if (w == acc_w && acc_we) begin
            ref_mem[acc_addr]  = acc_wdata;
            ref_seen[acc_addr] = 1'b1;
        end
        if (w == acc_w && !acc_we) pend_data = ref_rd(acc_addr);
        if (e >= free_at && (req0 || req1)) begin
            if (req0 && req1) win = RR ? pref : 1'b0;
            else              win = req1;
            pref      = !win;
            acc_port  = win;
            acc_we    = win ? we1 : we0;
            acc_addr  = win ? addr1 : addr0;
            acc_wdata = win ? wdata1 : wdata0;
            acc_w     = e;
            resp_w    = acc_we ? -10 : e + 1;
            free_at   = e + (acc_we ? 2 : 3);
            exp_addr  = acc_addr;
            exp_wdata = acc_wdata;
        end
        @(posedge clk);
        @(negedge clk);
        w++;
        check_window();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0 = 0; we0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
        #1;
        chk1("rst_gnt0", gnt0, 1'b0);
        chk1("rst_gnt1", gnt1, 1'b0);
        chk1("rst_rvalid0", rvalid0, 1'b0);
        chk1("rst_rvalid1", rvalid1, 1'b0);
        chk1("rst_mem_we", mem_we, 1'b0);
        chk32("rst_mem_addr", {{(DW-AW){1'b0}}, mem_addr}, '0);
        chk32("rst_mem_wdata", mem_wdata, '0);
        chk32("rst_rdata0", rdata0, '0);
        chk32("rst_rdata1", rdata1, '0);
        chk32("rst_state", {30'd0, fsm_state}, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n   = 1'b1;
        w       = 0;
        free_at = 1;
        acc_w   = -10;
        resp_w  = -10;
        acc_port = 0; acc_we = 0; pref = 0;
        acc_addr = '0; acc_wdata = '0; pend_data = '0;
        exp_addr = '0; exp_wdata = '0; exp_rd0 = '0; exp_rd1 = '0;
    endtask

    task automatic rand_port(input bit granted, inout logic r, inout logic we,
                             inout logic [AW-1:0] a, inout logic [DW-1:0] d);
        if (granted || !r) begin
            if ($urandom_range(0, 99) < 45) begin
                r  = 1'b1;
                we = 1'($urandom_range(0, 1));
                a  = AW'($urandom_range(0, 15));
                d  = $urandom;
            end else begin
                r = 1'b0;
            end
        end else if ($urandom_range(0, 99) < 8) begin
            r = 1'b0;
        end
    endtask

    initial begin
        #2;
        do_reset();

        // Port 0 write 0xDEADBEEF to 0x0010, granted on the first edge after reset.
        req0 = 1; we0 = 1; addr0 = AW'(16'h0010); wdata0 = 32'hDEADBEEF;
        tick();
        chk1("w26_gnt0", gnt0, 1'b1);
        chk1("w26_we", mem_we, 1'b1);
        req0 = 0; addr0 = '0; wdata0 = '0;
        tick();
        chk1("w26_we_drop", mem_we, 1'b0);
        chk32("w26_mem", mem_rd(AW'(16'h0010)), 32'hDEADBEEF);

        // Port 1 read of the same word.
        req1 = 1; we1 = 0; addr1 = AW'(16'h0010);
        tick();
        chk1("r27_gnt1", gnt1, 1'b1);
        req1 = 0;
        tick();
        chk1("r27_rvalid1", rvalid1, 1'b1);
        chk32("r27_rdata1", rdata1, 32'hDEADBEEF);
        tick();
        chk32("r27_hold", rdata1, 32'hDEADBEEF);

        // Port 0 pulses a request only while the FSM is in RESP.
        req1 = 1; we1 = 0; addr1 = AW'(16'h0003);
        tick();
        req1 = 0;
        tick();
        req0 = 1; we0 = 1; addr0 = AW'(16'h0030); wdata0 = 32'h0BADF00D;
        tick();
        req0 = 0;
        g0 = 0;
        repeat (3) begin
            tick();
            g0 += int'(gnt0);
        end
        chk32("r30_no_gnt0", 32'(g0), 32'd0);
        chk32("r30_mem", mem_rd(AW'(16'h0030)), ref_rd(AW'(16'h0030)));

        // Reset while a write to 0x0020 is in ACCESS.
        req0 = 1; we0 = 1; addr0 = AW'(16'h0020); wdata0 = 32'h12345678;
        tick();
        chk1("r29_access_we", mem_we, 1'b1);
        orig = ref_rd(AW'(16'h0020));
        do_reset();
        chk32("r29_mem_unchanged", mem_rd(AW'(16'h0020)), orig);

        // Continuous reads from both ports straight out of reset.
        req0 = 1; we0 = 0; addr0 = AW'(16'h0001);
        req1 = 1; we1 = 0; addr1 = AW'(16'h0002);
        g0 = 0; g1 = 0;
        repeat (12) begin
            tick();
            g0 += int'(gnt0);
            g1 += int'(gnt1);
        end
        chk32("r28_gnt0_count", 32'(g0), RR ? 32'd2 : 32'd4);
        chk32("r28_gnt1_count", 32'(g1), RR ? 32'd2 : 32'd0);

        // Random traffic.
        do_reset();
        repeat (400) begin
            rand_port((acc_w == w) && !acc_port, req0, we0, addr0, wdata0);
            rand_port((acc_w == w) && acc_port, req1, we1, addr1, wdata1);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout observed=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule
